// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared definitions for the SRAM arbiter: controller state
//               encoding, requester-ID encoding and SRAM bus widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int SRAM_AW = 18;          // SRAM word-address width
    localparam int SRAM_DW = 32;          // SRAM data width
    localparam int SRAM_BW = SRAM_DW / 8; // byte-enable width
    localparam int NUM_REQ = 3;           // number of requester slots

    // Controller states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Requester IDs; also the bit positions in grant/ack vectors
    typedef enum logic [1:0] {
        ID_VID = 2'd0,
        ID_CPU = 2'd1,
        ID_DMA = 2'd2
    } req_id_t;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pick
// Description : Combinational winner selector. Video has priority unless its
//               burst limit is reached while CPU/DMA waits; CPU vs DMA is
//               resolved by a round-robin pointer.
// Ports       : i_vid_req/i_cpu_req/i_dma_req - raw requests
//               i_ack_mask  - requesters excluded this cycle (bit = ID)
//               i_vid_limit - consecutive-video counter reached its limit
//               i_rr_dma    - round-robin pointer, 1 = DMA has the turn
//               o_grant     - one-hot grant, bit position = requester ID
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic               i_vid_req,
    input  logic               i_cpu_req,
    input  logic               i_dma_req,
    input  logic [NUM_REQ-1:0] i_ack_mask,
    input  logic               i_vid_limit,
    input  logic               i_rr_dma,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [NUM_REQ-1:0] w_req;
    logic               w_other;

    always_comb begin
        w_req   = {i_dma_req, i_cpu_req, i_vid_req} & ~i_ack_mask;
        w_other = w_req[ID_CPU] | w_req[ID_DMA];
        o_grant = '0;
        if (w_req[ID_VID] && !(i_vid_limit && w_other)) begin
            o_grant[ID_VID] = 1'b1;
        end else if (w_req[ID_CPU] && w_req[ID_DMA]) begin
            if (i_rr_dma) begin
                o_grant[ID_DMA] = 1'b1;
            end else begin
                o_grant[ID_CPU] = 1'b1;
            end
        end else if (w_req[ID_CPU]) begin
            o_grant[ID_CPU] = 1'b1;
        end else if (w_req[ID_DMA]) begin
            o_grant[ID_DMA] = 1'b1;
        end
    end

endmodule : sram_arb_pick
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Three-way (video / CPU / DMA) arbiter for a single-port
//               asynchronous SRAM. Each access is IDLE/DONE -> ACC
//               (1+WAIT_CYCLES cycles) -> DONE (one-cycle ack).
// Parameters  : WAIT_CYCLES - extra SRAM access cycles (0..7)
//               VID_BURST   - max consecutive video grants while CPU/DMA
//                             waits (1..255)
// Build macro : SRAM_ARB_DMA_EN - when defined the DMA port participates;
//               otherwise DMA inputs are ignored and dma_ack is tied low.
// Ports       : clk, rst (async, active high)
//               cpu_*  - CPU request/qualifiers, cpu_ack, cpu_stall
//               vid_*  - video read request, vid_ack
//               dma_*  - DMA request/qualifiers, dma_ack
//               rdata  - registered read data, valid while an ack is high
//               sr_*   - SRAM address/data/strobes, sr_din read data
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int VID_BURST   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [SRAM_BW-1:0] cpu_be,
    input  logic [SRAM_AW-1:0] cpu_adr,
    input  logic [SRAM_DW-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic               cpu_stall,
    input  logic               vid_req,
    input  logic [SRAM_AW-1:0] vid_adr,
    output logic               vid_ack,
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic [SRAM_BW-1:0] dma_be,
    input  logic [SRAM_AW-1:0] dma_adr,
    input  logic [SRAM_DW-1:0] dma_wdata,
    output logic               dma_ack,
    output logic [SRAM_DW-1:0] rdata,
    output logic [SRAM_AW-1:0] sr_adr,
    output logic [SRAM_DW-1:0] sr_dout,
    input  logic [SRAM_DW-1:0] sr_din,
    output logic               sr_we,
    output logic               sr_drive,
    output logic [SRAM_BW-1:0] sr_be
);

    localparam logic [2:0] c_wait      = 3'(WAIT_CYCLES);
    localparam logic [7:0] c_vid_burst = 8'(VID_BURST);

    state_t               r_state;
    state_t               w_next_state;
    logic [2:0]           r_acc_cnt;
    logic [7:0]           r_vid_cnt;
    req_id_t              r_owner;
    logic                 r_we;
    logic [NUM_REQ-1:0]   r_ack;
    logic [SRAM_DW-1:0]   r_rdata;
    logic [SRAM_AW-1:0]   r_sr_adr;
    logic [SRAM_DW-1:0]   r_sr_dout;
    logic [SRAM_BW-1:0]   r_sr_be;
    logic                 r_sr_we;

    logic                 w_arb_en;
    logic                 w_last;
    logic [NUM_REQ-1:0]   w_pick;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_any_grant;
    logic [NUM_REQ-1:0]   w_ack_mask;
    logic                 w_vid_limit;

    logic                 w_dma_req;
    logic                 w_dma_we;
    logic [SRAM_BW-1:0]   w_dma_be;
    logic [SRAM_AW-1:0]   w_dma_adr;
    logic [SRAM_DW-1:0]   w_dma_wdata;
    logic                 w_rr_dma;

    logic [SRAM_AW-1:0]   w_win_adr;
    logic [SRAM_DW-1:0]   w_win_dout;
    logic [SRAM_BW-1:0]   w_win_be;
    logic                 w_win_we;
    req_id_t              w_win_id;

`ifdef SRAM_ARB_DMA_EN
    logic r_rr_dma;

    assign w_dma_req   = dma_req;
    assign w_dma_we    = dma_we;
    assign w_dma_be    = dma_be;
    assign w_dma_adr   = dma_adr;
    assign w_dma_wdata = dma_wdata;
    assign w_rr_dma    = r_rr_dma;
    assign dma_ack     = r_ack[ID_DMA];

    // After a CPU/DMA grant the turn passes to the port that did not win
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_dma <= 1'b0;
        end else if (w_grant[ID_CPU]) begin
            r_rr_dma <= 1'b1;
        end else if (w_grant[ID_DMA]) begin
            r_rr_dma <= 1'b0;
        end
    end
`else
    logic w_unused_dma;

    assign w_dma_req    = 1'b0;
    assign w_dma_we     = 1'b0;
    assign w_dma_be     = '0;
    assign w_dma_adr    = '0;
    assign w_dma_wdata  = '0;
    assign w_rr_dma     = 1'b0;
    assign dma_ack      = 1'b0;
    assign w_unused_dma = ^{dma_req, dma_we, dma_be, dma_adr, dma_wdata};
`endif

    // A CPU/DMA requester still shows req during its ack cycle, so it is
    // masked there. Video is a streaming reader (held req = next word) and
    // is never masked, otherwise it could not get consecutive grants.
    assign w_ack_mask  = {r_ack[ID_DMA], r_ack[ID_CPU], 1'b0};
    assign w_vid_limit = (r_vid_cnt == c_vid_burst);

    sram_arb_pick u_pick (
        .i_vid_req   (vid_req),
        .i_cpu_req   (cpu_req),
        .i_dma_req   (w_dma_req),
        .i_ack_mask  (w_ack_mask),
        .i_vid_limit (w_vid_limit),
        .i_rr_dma    (w_rr_dma),
        .o_grant     (w_pick)
    );

    assign w_grant     = w_pick & {NUM_REQ{w_arb_en}};
    assign w_any_grant = |w_grant;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_any_grant) w_next_state = ST_ACC;
            ST_ACC:  if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = w_any_grant ? ST_ACC : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_arb_en = 1'b0;
        w_last   = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: w_arb_en = 1'b1;
            ST_ACC:           w_last   = (r_acc_cnt == c_wait);
            default:          w_arb_en = 1'b0;
        endcase
    end

    // Winner field selection; video and all reads use full byte enables
    always_comb begin
        w_win_adr  = vid_adr;
        w_win_dout = '0;
        w_win_be   = '1;
        w_win_we   = 1'b0;
        w_win_id   = ID_VID;
        if (w_grant[ID_CPU]) begin
            w_win_adr  = cpu_adr;
            w_win_dout = cpu_wdata;
            w_win_be   = cpu_we ? cpu_be : '1;
            w_win_we   = cpu_we;
            w_win_id   = ID_CPU;
        end else if (w_grant[ID_DMA]) begin
            w_win_adr  = w_dma_adr;
            w_win_dout = w_dma_wdata;
            w_win_be   = w_dma_we ? w_dma_be : '1;
            w_win_we   = w_dma_we;
            w_win_id   = ID_DMA;
        end
    end

    // Access datapath: capture on grant, complete on the last ACC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_cnt <= '0;
            r_owner   <= ID_VID;
            r_we      <= 1'b0;
            r_ack     <= '0;
            r_rdata   <= '0;
            r_sr_adr  <= '0;
            r_sr_dout <= '0;
            r_sr_be   <= '0;
            r_sr_we   <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_any_grant) begin
                r_acc_cnt <= '0;
                r_owner   <= w_win_id;
                r_we      <= w_win_we;
                r_sr_adr  <= w_win_adr;
                r_sr_dout <= w_win_dout;
                r_sr_be   <= w_win_be;
                r_sr_we   <= w_win_we;
            end else if (r_state == ST_ACC) begin
                if (w_last) begin
                    r_sr_we        <= 1'b0;
                    r_ack[r_owner] <= 1'b1;
                    if (!r_we) begin
                        r_rdata <= sr_din;
                    end
                end else begin
                    r_acc_cnt <= r_acc_cnt + 3'd1;
                end
            end
        end
    end

    // Consecutive-video counter, saturating at the burst limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vid_cnt <= '0;
        end else if (w_grant[ID_VID]) begin
            if (!w_vid_limit) begin
                r_vid_cnt <= r_vid_cnt + 8'd1;
            end
        end else if (w_any_grant) begin
            r_vid_cnt <= '0;
        end else if ((r_state == ST_IDLE) && !vid_req) begin
            r_vid_cnt <= '0;
        end
    end

    assign cpu_ack   = r_ack[ID_CPU];
    assign vid_ack   = r_ack[ID_VID];
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign rdata     = r_rdata;
    assign sr_adr    = r_sr_adr;
    assign sr_dout   = r_sr_dout;
    assign sr_be     = r_sr_be;
    assign sr_we     = r_sr_we;
    assign sr_drive  = r_sr_we;

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Scoreboard bench for sram_arbiter. Instance 0 uses
//               WAIT_CYCLES=0, instance 1 uses WAIT_CYCLES=2 (both
//               VID_BURST=8). Stimulus pushes expected acks (requester,
//               rdata, cycle); a negedge monitor pops and compares.
//               Build macro SRAM_ARB_DMA_EN selects the DMA scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req [2];
    logic        cpu_we [2];
    logic [3:0]  cpu_be [2];
    logic [17:0] cpu_adr [2];
    logic [31:0] cpu_wdata [2];
    logic        cpu_ack [2];
    logic        cpu_stall [2];
    logic        vid_req [2];
    logic [17:0] vid_adr [2];
    logic        vid_ack [2];
    logic        dma_req [2];
    logic        dma_we [2];
    logic [3:0]  dma_be [2];
    logic [17:0] dma_adr [2];
    logic [31:0] dma_wdata [2];
    logic        dma_ack [2];
    logic [31:0] rdata [2];
    logic [17:0] sr_adr [2];
    logic [31:0] sr_dout [2];
    logic [31:0] sr_din [2];
    logic        sr_we [2];
    logic        sr_drive [2];
    logic [3:0]  sr_be [2];

    typedef struct {
        logic [1:0]  id;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] last_rd [2];

    // SRAM contents model: word at 0x00010 reads 0xDEADBEEF
    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return 32'hDEADBEEF ^ {14'd0, a ^ 18'h00010};
    endfunction

    assign sr_din[0] = mem_word(sr_adr[0]);
    assign sr_din[1] = mem_word(sr_adr[1]);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.WAIT_CYCLES(0), .VID_BURST(8)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_be(cpu_be[0]),
        .cpu_adr(cpu_adr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_ack(cpu_ack[0]), .cpu_stall(cpu_stall[0]),
        .vid_req(vid_req[0]), .vid_adr(vid_adr[0]), .vid_ack(vid_ack[0]),
        .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_be(dma_be[0]),
        .dma_adr(dma_adr[0]), .dma_wdata(dma_wdata[0]), .dma_ack(dma_ack[0]),
        .rdata(rdata[0]), .sr_adr(sr_adr[0]), .sr_dout(sr_dout[0]),
        .sr_din(sr_din[0]), .sr_we(sr_we[0]), .sr_drive(sr_drive[0]),
        .sr_be(sr_be[0])
    );

    sram_arbiter #(.WAIT_CYCLES(2), .VID_BURST(8)) u_dut_w2 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_be(cpu_be[1]),
        .cpu_adr(cpu_adr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_ack(cpu_ack[1]), .cpu_stall(cpu_stall[1]),
        .vid_req(vid_req[1]), .vid_adr(vid_adr[1]), .vid_ack(vid_ack[1]),
        .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_be(dma_be[1]),
        .dma_adr(dma_adr[1]), .dma_wdata(dma_wdata[1]), .dma_ack(dma_ack[1]),
        .rdata(rdata[1]), .sr_adr(sr_adr[1]), .sr_dout(sr_dout[1]),
        .sr_din(sr_din[1]), .sr_we(sr_we[1]), .sr_drive(sr_drive[1]),
        .sr_be(sr_be[1])
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [1:0] id, input logic we,
                        input logic [17:0] adr, input int at);
        exp_t e;
        if (!we) last_rd[d] = mem_word(adr);
        e.id    = id;
        e.rdata = last_rd[d];
        e.cyc   = at;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input int d, input bit use_dma, input logic req, input logic we,
                         input logic [3:0] be, input logic [17:0] adr, input logic [31:0] wd);
        if (use_dma) begin
            dma_req[d] = req; dma_we[d] = we; dma_be[d] = be;
            dma_adr[d] = adr; dma_wdata[d] = wd;
        end else begin
            cpu_req[d] = req; cpu_we[d] = we; cpu_be[d] = be;
            cpu_adr[d] = adr; cpu_wdata[d] = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic mon(input int d, input logic [2:0] acks, input logic [31:0] rd);
        exp_t       e;
        logic [1:0] id;
        if (acks != 3'b000) begin
            n_tests++;
            if (!$onehot(acks)) begin
                n_fail++;
                $display("FAIL ack_onehot dut%0d: got acks=%b, required one-hot", d, acks);
            end else if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_fail++;
                $display("FAIL unexpected_ack dut%0d: got acks=%b at cycle %0d, required none", d, acks, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                id = acks[1] ? 2'd1 : (acks[2] ? 2'd2 : 2'd0);
                if (id !== e.id || rd !== e.rdata || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL sb_dut%0d: got id=%0d rdata=0x%h cyc=%0d, required id=%0d rdata=0x%h cyc=%0d",
                             d, id, rd, cyc, e.id, e.rdata, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, {dma_ack[0], cpu_ack[0], vid_ack[0]}, rdata[0]);
            mon(1, {dma_ack[1], cpu_ack[1], vid_ack[1]}, rdata[1]);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        bit  use_dma;
        logic [1:0] port_id;
`ifdef SRAM_ARB_DMA_EN
        use_dma = 1'b1;
        port_id = ID_DMA;
`else
        use_dma = 1'b0;
        port_id = ID_CPU;
`endif
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
            drive(d, 1'b1, 1'b0, 1'b0, 4'h0, '0, '0);
            vid_req[d] = 1'b0;
            vid_adr[d] = '0;
            last_rd[d] = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        // Reset state of both instances
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdata_dout", {rdata[d], sr_dout[d]}, 64'd0);
            chk("rst_ctl", {sr_adr[d], sr_be[d], sr_we[d], sr_drive[d],
                            cpu_ack[d], vid_ack[d], dma_ack[d]}, 64'd0);
        end

        // CPU read right at reset release: first arbitration on first edge
        rst = 1'b0;
        c0  = cyc;
        drive(0, 1'b0, 1'b1, 1'b0, 4'h0, 18'h00010, 32'h0);
        push(0, ID_CPU, 1'b0, 18'h00010, c0 + 2);
        #1;
        chk("stall_cyc0", cpu_stall[0], 1);
        tick();
        chk("stall_cyc1", cpu_stall[0], 1);
        chk("read_sr_adr", sr_adr[0], 18'h00010);
        chk("read_sr_be", sr_be[0], 4'hF);
        chk("read_sr_we", {sr_we[0], sr_drive[0]}, 2'b00);
        tick();
        chk("stall_cyc2", cpu_stall[0], 0);
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 18'h00010, 32'h0);
        tick();
        tick();

        // Video burst limit: 8 video, 1 CPU, video resumes
        c0 = cyc;
        vid_adr[0] = 18'h00100;
        vid_req[0] = 1'b1;
        drive(0, 1'b0, 1'b1, 1'b0, 4'h0, 18'h00200, 32'h0);
        for (int k = 0; k < 8; k++) push(0, ID_VID, 1'b0, 18'h00100, c0 + 2 + 2 * k);
        push(0, ID_CPU, 1'b0, 18'h00200, c0 + 18);
        push(0, ID_VID, 1'b0, 18'h00100, c0 + 20);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 18) drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 18'h00200, 32'h0);
            if (k == 20) vid_req[0] = 1'b0;
        end
        tick();
        tick();

        do_reset();
`ifdef SRAM_ARB_DMA_EN
        // CPU and DMA continuously: alternate every 2 cycles, CPU first
        c0 = cyc;
        drive(0, 1'b0, 1'b1, 1'b0, 4'h0, 18'h00300, 32'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 18'h00304, 32'h0);
        push(0, ID_CPU, 1'b0, 18'h00300, c0 + 2);
        push(0, ID_DMA, 1'b0, 18'h00304, c0 + 4);
        push(0, ID_CPU, 1'b0, 18'h00300, c0 + 6);
        push(0, ID_DMA, 1'b0, 18'h00304, c0 + 8);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) begin
                drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 18'h00300, 32'h0);
                drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 18'h00304, 32'h0);
            end
        end
`else
        // DMA write held high is ignored; held CPU read is masked in DONE
        c0 = cyc;
        drive(0, 1'b0, 1'b1, 1'b0, 4'h0, 18'h00300, 32'h0);
        drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 18'h00304, 32'hCAFEF00D);
        push(0, ID_CPU, 1'b0, 18'h00300, c0 + 2);
        push(0, ID_CPU, 1'b0, 18'h00300, c0 + 5);
        push(0, ID_CPU, 1'b0, 18'h00300, c0 + 8);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("dma_ack_tied", dma_ack[0], 0);
            chk("dma_no_write", sr_we[0], 0);
            if (k == 8) drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 18'h00300, 32'h0);
        end
        drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 18'h00304, 32'h0);
`endif
        tick();
        tick();

        // WAIT_CYCLES=2 partial write to top address
        c0 = cyc;
        drive(1, use_dma, 1'b1, 1'b1, 4'b0011, 18'h3FFFF, 32'h12345678);
        push(1, port_id, 1'b1, 18'h3FFFF, c0 + 4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k <= 3) chk("wr_we_drive", {sr_we[1], sr_drive[1]}, 2'b11);
            if (k == 1) begin
                chk("wr_sr_be", sr_be[1], 4'b0011);
                chk("wr_sr_adr", sr_adr[1], 18'h3FFFF);
                chk("wr_sr_dout", sr_dout[1], 32'h12345678);
            end
            if (k == 4) begin
                chk("wr_we_after", {sr_we[1], sr_drive[1]}, 2'b00);
                drive(1, use_dma, 1'b0, 1'b0, 4'h0, 18'h3FFFF, 32'h0);
            end
        end
        tick();
        tick();

        // Reset during the 2nd ACC cycle of a write aborts it
        drive(1, 1'b0, 1'b1, 1'b1, 4'hF, 18'h00055, 32'hA5A5A5A5);
        tick();
        tick();
        chk("abort_we_before", sr_we[1], 1);
        rst = 1'b1;
        #1;
        chk("abort_we_async", {sr_we[1], sr_drive[1]}, 2'b00);
        chk("abort_sr_adr", sr_adr[1], 18'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 18'h00055, 32'h0);
        tick();
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int k = 0; k < 4; k++) tick();
        chk("abort_no_ack", cpu_ack[1], 0);

        // Fresh read after the abort: full IDLE latency of 2+WAIT_CYCLES
        c0 = cyc;
        drive(1, 1'b0, 1'b1, 1'b0, 4'h0, 18'h00020, 32'h0);
        push(1, ID_CPU, 1'b0, 18'h00020, c0 + 4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 18'h00020, 32'h0);
        end
        tick();
        tick();
        tick();

        chk("sb_pending_dut0", q0.size(), 0);
        chk("sb_pending_dut1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters: WAIT_CYCLES, default 0, extra SRAM access cycles (0..7); VID_BURST, default 8, maximum consecutive video grants while another requester waits (1..255).
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cpu_req/cpu_we  in  1/1  CPU access request / write qualifier.
REQ-005 cpu_be  in  4  CPU byte enables (writes only).
REQ-006 cpu_adr/cpu_wdata  in  18/32  CPU word address / write data.
REQ-007 cpu_ack/cpu_stall  out  1/1  access complete / CPU hold (cpu_req & ~cpu_ack, combinational).
REQ-008 vid_req/vid_adr  in  1/18  video read request / word address.
REQ-009 vid_ack  out  1  video read complete.
REQ-010 dma_req/dma_we/dma_be/dma_adr/dma_wdata  in  1/1/4/18/32  DMA port, same meaning as CPU port.
REQ-011 dma_ack  out  1  DMA access complete.
REQ-012 rdata  out  32  registered read data, valid while any ack is high.
REQ-013 sr_adr/sr_dout  out  18/32  SRAM address / write data.
REQ-014 sr_din  in  32  SRAM read data.
REQ-015 sr_we/sr_drive/sr_be  out  1/1/4  write strobe (active high; external DDR stage) / data-bus drive enable / byte enables.

Function
REQ-016 States IDLE, ACC, DONE; ACC lasts exactly 1+WAIT_CYCLES cycles, counted by a 3-bit counter.
REQ-017 Arbitration in IDLE and DONE: video wins over CPU and DMA unless the consecutive-video counter equals VID_BURST and CPU or DMA is requesting.
REQ-018 CPU versus DMA: round-robin; the pointer flips to the other port after each CPU or DMA grant.
REQ-019 In DONE, the requester whose ack is high is excluded from arbitration.
REQ-020 On grant: the winner's address, write data, byte enables and write flag are registered into sr_adr/sr_dout/sr_be; state goes to ACC.
REQ-021 sr_be equals 4'b1111 for reads and for video.
REQ-022 sr_we and sr_drive are high in every ACC cycle of a write, and low otherwise.
REQ-023 On the last ACC cycle, rdata captures sr_din for reads and holds for writes; the winner's ack is set; state goes to DONE.
REQ-024 DONE lasts one cycle: ack high, then ack clears; the next state is ACC if another grant is made, else IDLE.
REQ-025 Latency, request in IDLE to ack: 2+WAIT_CYCLES cycles.
REQ-026 Back-to-back throughput: one access per 2+WAIT_CYCLES cycles.
REQ-027 Consecutive-video counter: increments on video grant (saturating at VID_BURST); clears on any non-video grant and whenever vid_req is low in IDLE.
REQ-028 Requesters hold req and qualifiers stable until ack; a request withdrawn before grant is ignored.
REQ-029 A request deasserted after grant does not abort the access.
REQ-030 At most one ack is high in any cycle.

Reset
REQ-031 Asynchronous reset forces: state IDLE, all acks 0, rdata 0, sr_adr 0, sr_dout 0, sr_be 0, sr_we 0, sr_drive 0, ACC counter 0, video counter 0, round-robin pointer to CPU.
REQ-032 Reset asserted mid-ACC aborts the access immediately and issues no ack.
REQ-033 After reset release, the first arbitration occurs on the first rising edge.

Configuration
REQ-034 With macro SRAM_ARB_DMA_EN defined, the DMA port participates as specified.
REQ-035 Without SRAM_ARB_DMA_EN, the DMA inputs are ignored, dma_ack is tied 0, and CPU is the only non-video requester; the round-robin pointer is omitted.

Structure
REQ-036 Shared package sram_arb_pkg holds: state enum, requester-ID encoding (VID=0, CPU=1, DMA=2), and constants SRAM_AW=18 and SRAM_DW=32.
REQ-037 One sub-module, sram_arb_pick, is natural: a combinational winner selector taking requests, ack mask, video counter flag and round-robin pointer, returning a one-hot grant.

Verification
REQ-038 WAIT_CYCLES=0; CPU read of 0x00010 with sr_din=0xDEADBEEF -> cpu_ack in cycle 2 with rdata=0xDEADBEEF, and cpu_stall high in cycles 0-1.
REQ-039 WAIT_CYCLES=2; DMA write of 0x12345678 to 0x3FFFF with be=0011 -> sr_we/sr_drive high for 3 cycles, sr_be=0011, then dma_ack in cycle 4.
REQ-040 vid_req held continuously with cpu_req high, VID_BURST=8 -> 8 vid_acks, then 1 cpu_ack, then video resumes.
REQ-041 CPU and DMA requesting continuously -> acks alternate CPU, DMA, CPU, DMA, one every 2 cycles.
REQ-042 rst pulsed during the 2nd ACC cycle of a write -> sr_we drops asynchronously, no ack is issued, and state is IDLE.
REQ-043 Build without SRAM_ARB_DMA_EN, dma_req held high -> dma_ack stays 0 and CPU accesses are unaffected.
